// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between requesters, the arbiter and the FIFO.
// stall_cnt_o exists only when FIFO_WR_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          busy_o;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]                   stall_cnt_o;

  modport master (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, fifo_wr_en_o, fifo_data_o,
    input  busy_o, stall_cnt_o
  );

  modport slave (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, fifo_wr_en_o, fifo_data_o,
    output busy_o, stall_cnt_o
  );
`else
  modport master (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, fifo_wr_en_o, fifo_data_o,
    input  busy_o
  );

  modport slave (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, fifo_wr_en_o, fifo_data_o,
    output busy_o
  );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port.
// Optional stall counter enabled by FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BURST);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] owner, owner_nx;
  logic [PW-1:0] rr_ptr, rr_nx;
  logic [BW-1:0] beat_cnt, cnt_nx;
  logic [BW-1:0] cnt_inc;

  logic [PW-1:0] winner;
  logic          found;
  logic          own_req;
  logic          full;
  logic          take;
  logic [PW-1:0] sel;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full    = bus.fifo_full_i;
  assign own_req = bus.req_i[owner];
  assign cnt_inc = beat_cnt + BW'(1);

  // First request at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_ptr;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_i[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    cnt_nx   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (found && !full) begin
          if (MAX_BURST == 1) begin
            rr_nx = wrap_inc(winner);
          end else begin
            state_nx = BURST;
            owner_nx = winner;
            cnt_nx   = BW'(1);
          end
        end
      end
      BURST: begin
        // A dropped request ends the burst; full only pauses it.
        if (!own_req) begin
          state_nx = IDLE;
          rr_nx    = wrap_inc(owner);
          cnt_nx   = '0;
        end else if (!full) begin
          if (cnt_inc == CNT_MAX) begin
            state_nx = IDLE;
            rr_nx    = wrap_inc(owner);
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    take = 1'b0;
    sel  = winner;
    if (!rst_i && !full) begin
      unique case (state)
        IDLE: begin
          take = found;
          sel  = winner;
        end
        BURST: begin
          take = own_req;
          sel  = owner;
        end
        default: take = 1'b0;
      endcase
    end
  end

  always_comb begin
    bus.gnt_o       = '0;
    bus.fifo_data_o = '0;
    if (take) begin
      bus.gnt_o[sel]  = 1'b1;
      bus.fifo_data_o =
        bus.data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.fifo_wr_en_o = take;
  assign bus.busy_o       = (state == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if ((|bus.req_i) && full &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: 4x8 burst instance and 3x1 round-robin instance.
// Stall counter is checked when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.DATA_WIDTH(64), .NUM_REQ(4)) a ();
  fifo_wr_arbiter_if #(.DATA_WIDTH(16), .NUM_REQ(3)) b ();

  fifo_wr_arbiter #(
    .DATA_WIDTH(64), .NUM_REQ(4), .MAX_BURST(8)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(a)
  );

  fifo_wr_arbiter #(
    .DATA_WIDTH(16), .NUM_REQ(3), .MAX_BURST(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(b)
  );

  typedef struct {
    logic        sel;
    logic [3:0]  gnt;
    logic [63:0] data;
    logic        busy;
    logic [15:0] stall;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [15:0] st_a = 16'd0;
  logic [15:0] st_b = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] da(input int k, input int c);
    return {32'hC0DE_0000 | 32'(k), 32'(c)};
  endfunction

  function automatic logic [15:0] db(input int k, input int c);
    return 16'(c * 3) ^ 16'(k * 16'h1000);
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string n, input int c,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               n, c, act, exp);
    end
  endtask

  task automatic cyc_a(input logic r, input logic [3:0] req,
                       input logic full, input logic [3:0] eg,
                       input logic eb);
    exp_t e;
    rst           = r;
    a.req_i       = req;
    a.fifo_full_i = full;
    for (int k = 0; k < 4; k++) a.data_i[k*64 +: 64] = da(k, cyc);
    b.req_i       = '0;
    b.fifo_full_i = 1'b0;
    b.data_i      = '0;
    if (r) st_a = 16'd0;
    if (r) st_b = 16'd0;
    e.sel   = 1'b0;
    e.gnt   = eg;
    e.data  = (eg != 4'd0) ? da(oh_idx(eg), cyc) : 64'd0;
    e.busy  = eb;
    e.stall = st_a;
    e.cyc   = cyc;
    q.push_back(e);
    if (!r && (req != 4'd0) && full && st_a != 16'hFFFF)
      st_a = st_a + 16'd1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cyc_b(input logic [2:0] req, input logic full,
                       input logic [2:0] eg);
    exp_t e;
    rst           = 1'b0;
    b.req_i       = req;
    b.fifo_full_i = full;
    for (int k = 0; k < 3; k++) b.data_i[k*16 +: 16] = db(k, cyc);
    a.req_i       = '0;
    a.fifo_full_i = 1'b0;
    a.data_i      = '0;
    e.sel   = 1'b1;
    e.gnt   = {1'b0, eg};
    e.data  = (eg != 3'd0) ? 64'(db(oh_idx({1'b0, eg}), cyc)) : 64'd0;
    e.busy  = 1'b0;
    e.stall = st_b;
    e.cyc   = cyc;
    q.push_back(e);
    if ((req != 3'd0) && full && st_b != 16'hFFFF)
      st_b = st_b + 16'd1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("a_gnt", e.cyc, 64'(a.gnt_o), 64'(e.gnt));
          chk("a_wr_en", e.cyc, 64'(a.fifo_wr_en_o), 64'(|e.gnt));
          chk("a_data", e.cyc, a.fifo_data_o, e.data);
          chk("a_busy", e.cyc, 64'(a.busy_o), 64'(e.busy));
`ifdef FIFO_WR_ARB_STATS_EN
          chk("a_stall", e.cyc, 64'(a.stall_cnt_o), 64'(e.stall));
`endif
        end else begin
          chk("b_gnt", e.cyc, 64'(b.gnt_o), 64'(e.gnt[2:0]));
          chk("b_wr_en", e.cyc, 64'(b.fifo_wr_en_o), 64'(|e.gnt));
          chk("b_data", e.cyc, 64'(b.fifo_data_o), e.data);
          chk("b_busy", e.cyc, 64'(b.busy_o), 64'(e.busy));
`ifdef FIFO_WR_ARB_STATS_EN
          chk("b_stall", e.cyc, 64'(b.stall_cnt_o), 64'(e.stall));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    a.req_i       = '0;
    a.data_i      = '0;
    a.fifo_full_i = 1'b0;
    b.req_i       = '0;
    b.data_i      = '0;
    b.fifo_full_i = 1'b0;
    @(posedge clk);
    #1;

    // reset priority, then requester 0 first
    cyc_a(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    cyc_a(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    // full bursts with rotation and no bubble
    repeat (7) cyc_a(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1);
    cyc_a(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b0);
    repeat (7) cyc_a(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1);
    cyc_a(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
    repeat (7) cyc_a(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1);
    cyc_a(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    // early release by requester 2
    cyc_a(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b0);
    repeat (2) cyc_a(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1);
    cyc_a(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1);
    cyc_a(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);
    repeat (7) cyc_a(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
    // full stall in the middle of requester 1's burst
    cyc_a(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
    repeat (3) cyc_a(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1);
    repeat (5) cyc_a(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1);
    repeat (4) cyc_a(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1);
    cyc_a(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc_a(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0);
    // async reset during beat 2, restart at requester 0
    cyc_a(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc_a(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    cyc_a(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    cyc_a(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    cyc_a(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // three requesters, single-beat grants
    repeat (2) begin
      cyc_b(3'b111, 1'b0, 3'b001);
      cyc_b(3'b111, 1'b0, 3'b010);
      cyc_b(3'b111, 1'b0, 3'b100);
    end
    cyc_b(3'b110, 1'b0, 3'b010);
    cyc_b(3'b011, 1'b0, 3'b001);
    cyc_b(3'b111, 1'b1, 3'b000);
    cyc_b(3'b100, 1'b0, 3'b100);
    cyc_b(3'b000, 1'b0, 3'b000);

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
